// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, execute-stage states and default width.
// Used by the ALU control decoder and by alu_exec_unit.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SLL   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_AND   = 4'd7,
        ALU_SUB   = 4'd8,
        ALU_SUBNE = 4'd10,
        ALU_SRA   = 4'd13
    } alu_ctrl_e;

    typedef enum logic {
        EX_IDLE  = 1'b0,
        EX_SHIFT = 1'b1
    } ex_state_e;

    localparam int XLEN_DEF = 32;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter for the execute stage.
// done flags the last step; data_next is the value that step produces.
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dir,
    input  logic               arith,
    input  logic [XLEN-1:0]    data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    data_next
);

    logic [XLEN-1:0]    data_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_q;
    logic               arith_q;

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == SHAMT_W'(1));

    // dir=1 shifts right; arith selects sign fill for right shifts
    assign data_next = dir_q ? {arith_q & data_q[XLEN-1], data_q[XLEN-1:1]}
                             : {data_q[XLEN-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            data_q  <= data_in;
            cnt_q   <= shamt;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (busy) begin
            data_q  <= data_next;
            cnt_q   <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32I execute stage with valid/ready handshakes on both sides.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts (no SHIFT state, no serial shifter).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    alu_ctrl_e          op_sel;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               accept;
    logic               imm_load;

    assign op_sel = alu_ctrl_e'(alu_ctrl);
    assign shamt  = op_b[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res = op_a + op_b;
        case (op_sel)
            ALU_SUB, ALU_SUBNE: alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
            // Only the zero-amount case completes here; others go to the serial shifter
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
            default:  alu_res = op_a + op_b;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    logic            sh_done;
    logic [XLEN-1:0] sh_next;

    assign sh_done  = 1'b0;
    assign sh_next  = '0;
    assign imm_load = accept;
    assign in_ready = !out_valid || out_ready;
`else
    ex_state_e       state;
    logic            is_shift;
    logic            start_shift;
    logic            sh_busy;
    logic            sh_done;
    logic [XLEN-1:0] sh_next;

    assign is_shift    = (op_sel == ALU_SLL) || (op_sel == ALU_SRL) || (op_sel == ALU_SRA);
    assign start_shift = accept && is_shift && (shamt != '0);
    assign imm_load    = accept && !start_shift;
    assign in_ready    = (state == EX_IDLE) && !sh_busy && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EX_IDLE;
        end else begin
            case (state)
                EX_IDLE:  if (start_shift) state <= EX_SHIFT;
                EX_SHIFT: if (sh_done)     state <= EX_IDLE;
                default:  state <= EX_IDLE;
            endcase
        end
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_shift),
        .dir       (op_sel != ALU_SLL),
        .arith     (op_sel == ALU_SRA),
        .data_in   (op_a),
        .shamt     (shamt),
        .busy      (sh_busy),
        .done      (sh_done),
        .data_next (sh_next)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (imm_load) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
            end else if (sh_done) begin
                out_valid <= 1'b1;
                result    <= sh_next;
                zero      <= (sh_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (default iterative-shift build).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = '0; op_a = '0; op_b = '0;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD 5+7
        drive(4'd0, 32'd5, 32'd7);
        tick(); in_valid = 1'b0;
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_result", result, 32'd12);
        chk("add_zero", {31'b0, zero}, 32'd0);

        // SUB then SUBNE back-to-back
        drive(4'd8, 32'd3, 32'd3);
        tick();
        chk("sub_result", result, 32'd0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        drive(4'd10, 32'd3, 32'd4);
        chk("subne_in_ready", {31'b0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        chk("subne_valid", {31'b0, out_valid}, 32'd1);
        chk("subne_result", result, 32'hFFFF_FFFF);
        chk("subne_zero", {31'b0, zero}, 32'd0);
        tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // SLT / SLTU
        drive(4'd2, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt_result", result, 32'd1);
        drive(4'd3, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("sltu_result", result, 32'd0);
        chk("sltu_zero", {31'b0, zero}, 32'd1);
        // unlisted code 9 behaves as ADD
        drive(4'd9, 32'd2, 32'd3);
        tick();
        chk("code9_result", result, 32'd5);
        // SRA with shamt 0 (b=32) completes like a non-shift op
        drive(4'd13, 32'h8000_0000, 32'd32);
        tick(); in_valid = 1'b0;
        chk("sra0_valid", {31'b0, out_valid}, 32'd1);
        chk("sra0_result", result, 32'h8000_0000);

        // SRA by 4: busy 4 cycles, result at N+5
        drive(4'd13, 32'h8000_0000, 32'd4);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sra_busy_in_ready", {31'b0, in_ready}, 32'd0);
            chk("sra_busy_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        chk("sra_valid", {31'b0, out_valid}, 32'd1);
        chk("sra_result", result, 32'hF800_0000);
        drive(4'd5, 32'h8000_0000, 32'd4);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("srl_busy_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        chk("srl_valid", {31'b0, out_valid}, 32'd1);
        chk("srl_result", result, 32'h0800_0000);

        // Maximum shift: SRL by 31 lands at N+32
        drive(4'd5, 32'hFFFF_FFFF, 32'd31);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("srl31_not_yet", {31'b0, out_valid}, 32'd0);
        tick();
        chk("srl31_valid", {31'b0, out_valid}, 32'd1);
        chk("srl31_result", result, 32'd1);
        tick();

        // Backpressure on an XOR result
        out_ready = 1'b0;
        drive(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick();
        drive(4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'h0FF0_0FF0);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        chk("bp_held_result", result, 32'h0FF0_0FF0);
        out_ready = 1'b1;
        #1;
        chk("bp_drain_in_ready", {31'b0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        chk("bp_new_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_new_result", result, 32'd3);
        tick();
        chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);

        // Reset during a long SLL
        drive(4'd1, 32'd1, 32'd20);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_shift_in_ready", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        drive(4'd0, 32'd1, 32'd1);
        tick(); in_valid = 1'b0;
        chk("post_rst_add_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_add_result", result, 32'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
